uart_periph: RTL



---
 rtl/uart_periph.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - memory-mapped UART (TXD/RXD/CON) with level IRQ; UART_LOOPBACK_EN adds CON[6] internal loopback
module uart_periph #(
    parameter logic [31:0] BASE    = 32'h40000018,
    parameter int          CLK_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        en,
    output logic        irqout,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic hit_txd, hit_rxd, hit_con;
    logic tx_write, con_write, rxd_read;

    assign hit_txd   = (addr == BASE);
    assign hit_rxd   = (addr == BASE + 32'd4);
    assign hit_con   = (addr == BASE + 32'd8);
    assign en        = (rd | wr) & (hit_txd | hit_rxd | hit_con);
    assign tx_write  = wr & hit_txd;
    assign con_write = wr & hit_con;
    assign rxd_read  = rd & hit_rxd;

    logic [7:0] tx_data, rx_data;
    logic       tx_done, tx_irq_en, rx_irq_en, rx_valid, rx_overrun, tx_busy;
    logic       lb_bit;
    logic       unused_bits;

    assign unused_bits = ^wdata;

    // TX path
    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n;
    logic          tx_end, tx_accept;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_end     = 1'b0;
        tx_accept  = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (tx_write) begin
                    tx_accept  = 1'b1;
                    tx_shift_n = wdata[7:0];
                    tx_state_n = S_START;
                end
            end
            S_START: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n   = '0;
                tx_bit_n   = 3'd0;
                tx_state_n = S_DATA;
            end
            S_DATA: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_n = S_STOP;
            end
            S_STOP: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n   = '0;
                tx_end     = 1'b1;
                tx_state_n = S_IDLE;
            end
            default: tx_state_n = S_IDLE;
        endcase
        // line is registered from the next state so the pin never glitches
        tx_line_n = (tx_state_n == S_DATA) ? tx_shift_n[0] : (tx_state_n != S_START);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    assign tx_busy = (tx_state != S_IDLE);

    // RX path
    logic rx_s1, rx_s2, rx_in, rx_prev;

`ifdef UART_LOOPBACK_EN
    logic loopback;
    assign rx_in   = loopback ? tx_line : rx_s2;
    assign uart_tx = loopback ? 1'b1 : tx_line;
    assign lb_bit  = loopback;
`else
    assign rx_in   = rx_s2;
    assign uart_tx = tx_line;
    assign lb_bit  = 1'b0;
`endif

    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_store;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_store   = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev & ~rx_in) rx_state_n = S_START;
            end
            S_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_bit_n   = 3'd0;
                rx_state_n = rx_in ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_in, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = S_STOP;
            end
            S_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_store   = rx_in;
                rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_in;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Software-visible registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data    <= 8'h00;
            tx_done    <= 1'b0;
            tx_irq_en  <= 1'b0;
            rx_irq_en  <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_LOOPBACK_EN
            loopback   <= 1'b0;
`endif
        end else begin
            if (tx_accept) tx_data <= wdata[7:0];
            if (con_write) begin
                tx_irq_en <= wdata[0];
                rx_irq_en <= wdata[1];
`ifdef UART_LOOPBACK_EN
                loopback  <= wdata[6];
`endif
            end
            // frame end beats a simultaneous write-1-to-clear
            if (tx_end) tx_done <= 1'b1;
            else if (con_write & wdata[3]) tx_done <= 1'b0;
            if (rx_store) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rxd_read ? 1'b0 : (rx_overrun | rx_valid);
            end else if (rxd_read) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            if (hit_txd)      rdata = {24'h0, tx_data};
            else if (hit_rxd) rdata = {24'h0, rx_data};
            else if (hit_con) rdata = {25'h0, lb_bit, rx_overrun, tx_busy, tx_done,
                                       rx_valid, rx_irq_en, tx_irq_en};
        end
    end

    assign irqout = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);

endmodule
